// File: rtl/sa_tile_sequencer_if.sv
// Job-request and result-drain handshakes of the systolic tile sequencer.
// The sequencer takes the slave side; the job source/result sink the master.
interface sa_tile_sequencer_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int K_WIDTH    = 8
);
  localparam int ROW_W = $clog2(ARRAY_SIZE);

  logic               start_v_i;
  logic [K_WIDTH-1:0] k_len_i;
  logic               start_ready_o;
  logic               drain_v_o;
  logic               drain_ready_i;
  logic [ROW_W-1:0]   drain_row_o;

  modport master (
    output start_v_i, k_len_i, drain_ready_i,
    input  start_ready_o, drain_v_o, drain_row_o
  );

  modport slave (
    input  start_v_i, k_len_i, drain_ready_i,
    output start_ready_o, drain_v_o, drain_row_o
  );
endinterface

// File: rtl/sa_tile_sequencer.sv
// Sequences one tile pass: clear, skewed feed, flush, row drain, done.
// Optional job cycle counter enabled by SA_TILE_SEQ_PERF_EN.
module sa_tile_sequencer #(
  parameter int ARRAY_SIZE = 4,
  parameter int K_WIDTH    = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  sa_tile_sequencer_if.slave    job_if,
  input  logic                  abort_i,
  output logic                  pe_clear_o,
  output logic [ARRAY_SIZE-1:0] feed_en_o,
  output logic [K_WIDTH:0]      rd_addr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           perf_cycles_o
);
  localparam int ROW_W = $clog2(ARRAY_SIZE);
  localparam int TW    = K_WIDTH + 1;
  localparam int EW    = K_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t             state, state_n;
  logic [TW-1:0]      t;
  logic [ROW_W-1:0]   row;
  logic [K_WIDTH-1:0] k;
  logic [TW-1:0]      t_last;
  logic               t_end, flush_end, row_last;
  logic               accept, kill;

  // t doubles as the flush-cycle counter; rd_addr_o is gated to FEED
  assign t_last    = {1'b0, k} + TW'(ARRAY_SIZE - 2);
  assign t_end     = t == t_last;
  assign flush_end = t == TW'(ARRAY_SIZE - 1);
  assign row_last  = row == ROW_W'(ARRAY_SIZE - 1);
  assign accept    = (state == S_IDLE) && job_if.start_v_i;
  assign kill      = abort_i && (state != S_IDLE);

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (job_if.start_v_i)
          state_n = (job_if.k_len_i == '0) ? S_DONE : S_CLEAR;
      S_CLEAR: state_n = S_FEED;
      S_FEED:  if (t_end) state_n = S_FLUSH;
      S_FLUSH: if (flush_end) state_n = S_DRAIN;
      S_DRAIN:
        if (job_if.drain_ready_i && row_last) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (kill) state_n = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      t   <= '0;
      row <= '0;
      k   <= '0;
    end else if (kill) begin
      t   <= '0;
      row <= '0;
      k   <= '0;
    end else begin
      unique case (state)
        S_IDLE:
          if (accept) begin
            k   <= job_if.k_len_i;
            t   <= '0;
            row <= '0;
          end
        S_CLEAR: t <= '0;
        S_FEED:  t <= t_end ? '0 : t + TW'(1);
        S_FLUSH: t <= flush_end ? '0 : t + TW'(1);
        S_DRAIN:
          if (job_if.drain_ready_i)
            row <= row_last ? '0 : row + ROW_W'(1);
        S_DONE:  ;
        default: ;
      endcase
    end
  end

  // row i sees operands for t in [i, i+K)
  always_comb begin
    feed_en_o = '0;
    for (int i = 0; i < ARRAY_SIZE; i++)
      feed_en_o[i] = (state == S_FEED)
                  && ({1'b0, t} >= EW'(i))
                  && ({1'b0, t} < EW'(i) + {2'b0, k});
  end

  assign rd_addr_o            = (state == S_FEED) ? t : '0;
  assign pe_clear_o           = state == S_CLEAR;
  assign busy_o               = state != S_IDLE;
  assign done_o               = state == S_DONE;
  assign job_if.start_ready_o = state == S_IDLE;
  assign job_if.drain_v_o     = state == S_DRAIN;
  assign job_if.drain_row_o   = (state == S_DRAIN) ? row : '0;

`ifdef SA_TILE_SEQ_PERF_EN
  logic [31:0] perf;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n)
      perf <= '0;
    else if (kill || accept)
      perf <= '0;
    else if (state != S_IDLE && perf != '1)
      perf <= perf + 32'd1;
  end

  assign perf_cycles_o = perf;
`else
  assign perf_cycles_o = '0;
`endif
endmodule

// File: doc/sa_tile_sequencer.md
Name: sa_tile_sequencer

Overview:
- Controller that sequences one matrix-tile pass through the ARRAY_SIZE x ARRAY_SIZE PE systolic array.
- Accepts a job of depth K over a valid/ready handshake.
- Clears the PE accumulators, then generates the skewed per-row operand feed enables and the operand-buffer read address.
- Waits for the array pipeline to flush, drains one result row per handshake, then pulses done.

Parameters:
- ARRAY_SIZE, 4, rows/columns of the PE array; legal range 2..16.
- K_WIDTH, 8, width of the job depth and of the feed counter.
- ROW_W, $clog2(ARRAY_SIZE), width of drain_row_o (derived; not overridden).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_v_i  in  1  job request valid.
- k_len_i  in  K_WIDTH  job depth K; sampled on accept.
- start_ready_o  out  1  high only in IDLE.
- abort_i  in  1  synchronous abort.
- pe_clear_o  out  1  PE accumulator clear; drives PE reset.
- feed_en_o  out  ARRAY_SIZE  per-row operand valid, skewed.
- rd_addr_o  out  K_WIDTH+1  feed step counter t; operand-buffer base address.
- drain_v_o  out  1  result row valid.
- drain_ready_i  in  1  downstream accepts the row.
- drain_row_o  out  ROW_W  index of the row being drained.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle job-complete pulse.
- perf_cycles_o  out  32  job cycle count (see Optional Feature).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; t, drain row counter and latched K all 0.
  - All outputs 0 except start_ready_o = 1.
- Accept: start_v_i && start_ready_o at a rising edge; K is latched from k_len_i.
- States and transitions:
  - IDLE -> CLEAR on accept with K != 0.
  - IDLE -> DONE on accept with K == 0; no clear, feed or drain.
  - CLEAR, 1 cycle: pe_clear_o = 1; then -> FEED with t = 0.
  - FEED, K+ARRAY_SIZE-1 cycles, t = 0 .. K+ARRAY_SIZE-2:
    - feed_en_o[i] = (t >= i) && (t < i+K).
    - rd_addr_o = t.
    - -> FLUSH after the last t.
  - FLUSH, ARRAY_SIZE cycles: all feed_en_o = 0; then -> DRAIN with row = 0.
  - DRAIN:
    - drain_v_o = 1, drain_row_o = row.
    - row increments on drain_v_o && drain_ready_i.
    - Handshake on row ARRAY_SIZE-1 -> DONE.
    - drain_v_o and drain_row_o hold stable while drain_ready_i is low (no timeout).
  - DONE, 1 cycle: done_o = 1; then -> IDLE.
- Outputs outside their state are 0: feed_en_o outside FEED, rd_addr_o outside FEED, drain_v_o outside DRAIN.
- Latency, with drain_ready_i held high: accept to done_o pulse = 3*ARRAY_SIZE + K + 1 cycles. done_o is high in cycle N after accept, where accept is cycle 0.
- Abort:
  - abort_i high in any state other than IDLE -> IDLE at the next edge.
  - No done_o pulse, counters cleared, outputs return to IDLE values.
  - abort_i is ignored in IDLE; a simultaneous start is accepted.
- Maximum depth K = 2^K_WIDTH-1: t must not wrap, hence rd_addr_o is K_WIDTH+1 bits wide.
- start_v_i while busy is ignored; start_ready_o = 0 outside IDLE.
- No combinational path from any input to any output except start_ready_o, which is derived from state only.

Optional Feature:
- Macro: SA_TILE_SEQ_PERF_EN.
- Defined:
  - perf_cycles_o counts cycles spent in CLEAR through DONE inclusive, stall cycles included.
  - Cleared on accept; holds its value after DONE until the next accept.
  - Cleared by reset and by abort.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: perf_cycles_o is tied to 0; no counter logic is generated.

Test Plan:
- Reset: reset_n low mid-FEED with no clock edge -> immediately state IDLE, start_ready_o = 1, feed_en_o = 0, pe_clear_o = 0.
- ARRAY_SIZE = 4, K = 3, drain_ready_i = 1:
  - pe_clear_o in cycle 1.
  - feed_en_o sequence over t = 0..5: 0001, 0011, 0111, 1110, 1100, 1000.
  - drain rows 0..3 in cycles 12..15; done_o in cycle 16.
  - perf_cycles_o = 16 (macro defined).
- K = 0 accepted -> done_o one cycle later; no pe_clear_o, feed_en_o or drain_v_o activity.
- DRAIN with drain_ready_i low for 5 cycles on row 2 -> drain_row_o held at 2 and drain_v_o held at 1; done_o delayed by 5 cycles; perf_cycles_o = 21.
- abort_i in FLUSH -> IDLE next cycle, no done_o. New start with K = 1 completes normally in 14 cycles.
- K = 255, ARRAY_SIZE = 4:
  - rd_addr_o reaches 257 without wrap.
  - feed_en_o[3] high for t = 3..257.
  - done_o at cycle 268.
